gate_bist_ctrl: RTL and testbench

Built-in self-test controller that wraps the two-input logic-gate block. It drives the gate block's `a`/`b` inputs through all four input combinations. It samples the eight returned gate outputs after a programmable settle time and compares each against a fixed truth table. At the end of a run it reports pass/fail, a saturating mismatch count, and the first failing vector.

---
 rtl/gate_bist_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// BIST controller: sweeps {a,b} over all four vectors, checks the eight
// returned gate outputs against the truth table and reports the run result.
module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             a,
    output logic             b,
    input  logic [7:0]       gate_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic [7:0]       first_fail_mask
);

    localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0] PASS_LAST   = PC_W'(PASSES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [1:0]       vec_idx, vec_next;
    logic [PC_W-1:0]  pass_idx, pass_idx_next;
    logic [SC_W-1:0]  settle_cnt, settle_next;
    logic             found, found_next;
    logic             ab_a_next, ab_b_next, busy_next, done_next, pass_next;
    logic [CNT_W-1:0] err_next;
    logic [1:0]       ffv_next;
    logic [7:0]       ffm_next;
    logic [7:0]       exp_vec;
    logic             mismatch;

    // Golden gate response for a given {a,b}
    function automatic logic [7:0] expected(input logic [1:0] v);
        case (v)
            2'b00:   return 8'h3D;
            2'b01:   return 8'h72;
            2'b10:   return 8'h6A;
            default: return 8'hC1;
        endcase
    endfunction

    assign exp_vec  = expected(vec_idx);
    assign mismatch = (gate_out != exp_vec);

    // Next-state and next-output logic
    always_comb begin
        state_next    = state;
        vec_next      = vec_idx;
        pass_idx_next = pass_idx;
        settle_next   = settle_cnt;
        found_next    = found;
        done_next     = 1'b0;
        pass_next     = pass;
        err_next      = err_count;
        ffv_next      = first_fail_vec;
        ffm_next      = first_fail_mask;

        if (abort && state != IDLE) begin
            // Cancel: partial error results stay visible, pass is withdrawn
            state_next = IDLE;
            pass_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state_next    = SETTLE;
                        vec_next      = 2'b00;
                        pass_idx_next = '0;
                        settle_next   = SETTLE_LOAD;
                        found_next    = 1'b0;
                        pass_next     = 1'b0;
                        err_next      = '0;
                        ffv_next      = 2'b00;
                        ffm_next      = 8'h00;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state_next = CHECK;
                    end else begin
                        settle_next = settle_cnt - SC_W'(1);
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != {CNT_W{1'b1}}) begin
                            err_next = err_count + CNT_W'(1);
                        end
                        if (!found) begin
                            found_next = 1'b1;
                            ffv_next   = vec_idx;
                            ffm_next   = exp_vec ^ gate_out;
                        end
                    end
                    if (vec_idx == 2'b11 && pass_idx == PASS_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        pass_next  = (err_next == '0);
                    end else begin
                        state_next  = SETTLE;
                        settle_next = SETTLE_LOAD;
                        vec_next    = vec_idx + 2'd1;
                        if (vec_idx == 2'b11) begin
                            pass_idx_next = pass_idx + PC_W'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        busy_next = (state_next != IDLE);
        ab_a_next = busy_next & vec_next[1];
        ab_b_next = busy_next & vec_next[0];
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            vec_idx         <= 2'b00;
            pass_idx        <= '0;
            settle_cnt      <= '0;
            found           <= 1'b0;
            a               <= 1'b0;
            b               <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= 2'b00;
            first_fail_mask <= 8'h00;
        end else begin
            state           <= state_next;
            vec_idx         <= vec_next;
            pass_idx        <= pass_idx_next;
            settle_cnt      <= settle_next;
            found           <= found_next;
            a               <= ab_a_next;
            b               <= ab_b_next;
            busy            <= busy_next;
            done            <= done_next;
            pass            <= pass_next;
            err_count       <= err_next;
            first_fail_vec  <= ffv_next;
            first_fail_mask <= ffm_next;
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench: three controller configurations, each wrapping a
// behavioural gate block with per-vector fault injection.
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_r [3];
    logic       abort_r [3];
    logic       a_w     [3];
    logic       b_w     [3];
    logic [7:0] gate_w  [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       pass_w  [3];
    logic [7:0] ec_w    [3];
    logic [1:0] ffv_w   [3];
    logic [7:0] ffm_w   [3];
    logic [7:0] fm      [3][4];
    logic [1:0] ec1;

    int checks = 0;
    int errors = 0;

    // Reference gate block built from the boolean functions themselves
    function automatic logic [7:0] golden(input logic x, input logic y);
        return {x & y, x | y, ~(x & y), ~x, ~y, ~(x | y), x ^ y, ~(x ^ y)};
    endfunction

    function automatic int s_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic int p_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int cw_of(input int i);
        return (i == 1) ? 2 : 8;
    endfunction

    assign gate_w[0] = golden(a_w[0], b_w[0]) ^ fm[0][{a_w[0], b_w[0]}];
    assign gate_w[1] = golden(a_w[1], b_w[1]) ^ fm[1][{a_w[1], b_w[1]}];
    assign gate_w[2] = golden(a_w[2], b_w[2]) ^ fm[2][{a_w[2], b_w[2]}];
    assign ec_w[1]   = {6'b0, ec1};

    gate_bist_ctrl u0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .abort(abort_r[0]),
        .a(a_w[0]), .b(b_w[0]), .gate_out(gate_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .pass(pass_w[0]), .err_count(ec_w[0]),
        .first_fail_vec(ffv_w[0]), .first_fail_mask(ffm_w[0])
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .abort(abort_r[1]),
        .a(a_w[1]), .b(b_w[1]), .gate_out(gate_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .pass(pass_w[1]), .err_count(ec1),
        .first_fail_vec(ffv_w[1]), .first_fail_mask(ffm_w[1])
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(2), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .start(start_r[2]), .abort(abort_r[2]),
        .a(a_w[2]), .b(b_w[2]), .gate_out(gate_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .pass(pass_w[2]), .err_count(ec_w[2]),
        .first_fail_vec(ffv_w[2]), .first_fail_mask(ffm_w[2])
    );

    task automatic set_masks(input int inst, input logic [7:0] m0, input logic [7:0] m1,
                             input logic [7:0] m2, input logic [7:0] m3);
        fm[inst][0] = m0; fm[inst][1] = m1; fm[inst][2] = m2; fm[inst][3] = m3;
    endtask

    // Full run on one instance, checked cycle by cycle against the model
    task automatic run_check(input int inst, input string name, input int restart_at);
        int s, p, n, cnt, maxc, vexp;
        logic       found;
        logic [1:0] fv;
        logic [7:0] fmk;
        s = s_of(inst); p = p_of(inst); n = 4 * p * (s + 1);
        maxc = (1 << cw_of(inst)) - 1;
        cnt = 0; found = 1'b0; fv = 2'b00; fmk = 8'h00;
        for (int pi = 0; pi < p; pi++) begin
            for (int v = 0; v < 4; v++) begin
                if (fm[inst][v] != 8'h00) begin
                    if (cnt < maxc) cnt++;
                    if (!found) begin
                        found = 1'b1; fv = 2'(v); fmk = fm[inst][v];
                    end
                end
            end
        end
        @(negedge clk) start_r[inst] = 1'b1;
        @(negedge clk) start_r[inst] = 1'b0;
        for (int k = 0; k < n; k++) begin
            start_r[inst] = (k == restart_at);
            vexp = (k / (s + 1)) % 4;
            checks++;
            if (busy_w[inst] !== 1'b1) begin
                errors++; $display("FAIL %s busy k=%0d got %b want 1", name, k, busy_w[inst]);
            end
            checks++;
            if ({a_w[inst], b_w[inst]} !== 2'(vexp)) begin
                errors++;
                $display("FAIL %s ab k=%0d got %b%b want %0d", name, k, a_w[inst], b_w[inst], vexp);
            end
            checks++;
            if (done_w[inst] !== 1'b0) begin
                errors++; $display("FAIL %s early_done k=%0d got %b want 0", name, k, done_w[inst]);
            end
            @(negedge clk);
        end
        start_r[inst] = 1'b0;
        checks++;
        if (busy_w[inst] !== 1'b0 || done_w[inst] !== 1'b1) begin
            errors++;
            $display("FAIL %s end busy/done got %b/%b want 0/1", name, busy_w[inst], done_w[inst]);
        end
        checks++;
        if (pass_w[inst] !== (cnt == 0)) begin
            errors++; $display("FAIL %s pass got %b want %0d", name, pass_w[inst], cnt == 0);
        end
        checks++;
        if (ec_w[inst] !== 8'(cnt)) begin
            errors++; $display("FAIL %s err_count got %0d want %0d", name, ec_w[inst], cnt);
        end
        checks++;
        if (ffv_w[inst] !== fv || ffm_w[inst] !== fmk) begin
            errors++;
            $display("FAIL %s first_fail got %b/%h want %b/%h", name, ffv_w[inst], ffm_w[inst], fv, fmk);
        end
        @(negedge clk);
        checks++;
        if (done_w[inst] !== 1'b0 || busy_w[inst] !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done busy/done got %b/%b want 0/0", name, busy_w[inst], done_w[inst]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i]} !== 5'b0 ||
                ec_w[i] !== 8'h00 || ffv_w[i] !== 2'b00 || ffm_w[i] !== 8'h00) begin
                errors++; $display("FAIL reset inst%0d outputs not all zero got busy=%b ec=%0d", i, busy_w[i], ec_w[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_golden();
        set_masks(0, 8'h00, 8'h00, 8'h00, 8'h00);
        run_check(0, "golden", -1);
    endtask

    task automatic test_xor_stuck();
        set_masks(0, golden(1'b0, 1'b0) & 8'h02, golden(1'b0, 1'b1) & 8'h02,
                  golden(1'b1, 1'b0) & 8'h02, golden(1'b1, 1'b1) & 8'h02);
        run_check(0, "xor_stuck", -1);
    endtask

    task automatic test_saturate();
        set_masks(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_check(1, "saturate", -1);
    endtask

    task automatic test_passes();
        set_masks(2, 8'h00, 8'h00, 8'h00, 8'h00);
        run_check(2, "passes2", -1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int inst;
            inst = int'($urandom_range(0, 2));
            for (int v = 0; v < 4; v++) begin
                fm[inst][v] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            end
            run_check(inst, "random", -1);
        end
    endtask

    task automatic test_abort();
        set_masks(0, 8'h01, 8'h00, 8'h00, 8'h00);
        @(negedge clk) start_r[0] = 1'b1;
        @(negedge clk) start_r[0] = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({a_w[0], b_w[0]} !== 2'b10) begin
            errors++; $display("FAIL abort_pos ab got %b%b want 10", a_w[0], b_w[0]);
        end
        abort_r[0] = 1'b1;
        start_r[0] = 1'b1;
        @(negedge clk);
        abort_r[0] = 1'b0;
        start_r[0] = 1'b0;
        checks++;
        if ({busy_w[0], a_w[0], b_w[0], done_w[0], pass_w[0]} !== 5'b0) begin
            errors++;
            $display("FAIL abort outputs got busy=%b ab=%b%b done=%b pass=%b want 0", busy_w[0],
                     a_w[0], b_w[0], done_w[0], pass_w[0]);
        end
        checks++;
        if (ec_w[0] !== 8'd1 || ffv_w[0] !== 2'b00 || ffm_w[0] !== 8'h01) begin
            errors++;
            $display("FAIL abort_partial got ec=%0d ffv=%b ffm=%h want 1/00/01", ec_w[0], ffv_w[0], ffm_w[0]);
        end
        start_r[0] = 1'b1;
        abort_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        abort_r[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
                errors++; $display("FAIL start_abort_idle k=%0d got busy=%b want 0", k, busy_w[0]);
            end
            @(negedge clk);
        end
        set_masks(0, 8'h00, 8'h00, 8'h00, 8'h00);
        run_check(0, "restart_ignored", 2);
    endtask

    task automatic test_rst_mid();
        set_masks(0, 8'h00, 8'h80, 8'h00, 8'h00);
        @(negedge clk) start_r[0] = 1'b1;
        @(negedge clk) start_r[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0]} !== 5'b0 ||
            ec_w[0] !== 8'h00 || ffv_w[0] !== 2'b00 || ffm_w[0] !== 8'h00) begin
            errors++; $display("FAIL rst_mid outputs got busy=%b ec=%0d ffm=%h want 0", busy_w[0], ec_w[0], ffm_w[0]);
        end
        set_masks(0, 8'h00, 8'h00, 8'h00, 8'h00);
        run_check(0, "after_rst", -1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            abort_r[i] = 1'b0;
            set_masks(i, 8'h00, 8'h00, 8'h00, 8'h00);
        end
        test_reset();
        test_golden();
        test_xor_stuck();
        test_saturate();
        test_passes();
        test_abort();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
